age_ordered_unit_arbiter: RTL and testbench

Shares a pool of NUM_UNITS identical execution units (ALUs) among NUM_PORTS single-instruction controllers. Grants go oldest-first by issue ID, with wrap-aware comparison. A granted unit is held exclusively until the owner releases it, drops its request, or a rollback flushes all ownership. The block sits between the SIC array and the ALU pool. Its per-port grant and unit index select which ALU each SIC's operand bus is routed to.

---
 rtl/age_ordered_unit_arbiter.sv | 142 ++++++++++++++
 tb/tb_age_ordered_unit_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/age_ordered_unit_arbiter.sv
// age_ordered_unit_arbiter: lends NUM_UNITS shared execution units to NUM_PORTS
// requesters, oldest issue ID first (wrap-aware), with exclusive hold and forced timeout.
`default_nettype none

module age_ordered_unit_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int NUM_UNITS = 4,
   parameter int ID_WIDTH  = 16,
   parameter int MAX_HOLD  = 15
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic [NUM_PORTS-1:0]                                   req_valid,
   input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]                     req_id,
   input  logic [NUM_PORTS-1:0]                                   release_unit,
   input  logic                                                   flush,
   output logic [NUM_PORTS-1:0]                                   grant,
   output logic [NUM_PORTS-1:0][(NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1)-1:0] grant_unit,
   output logic [NUM_UNITS-1:0]                                   unit_busy,
   output logic [NUM_PORTS-1:0]                                   hold_timeout
);

   localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HELD = 2'd2
   } state_t;

   state_t          state    [NUM_PORTS];
   logic [CW-1:0]   hold_cnt [NUM_PORTS];
   logic [CW-1:0]   cnt_inc  [NUM_PORTS];
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] win;
   logic [UW-1:0]   win_unit [NUM_PORTS];
   int              rank     [NUM_PORTS];
   logic [NUM_UNITS-1:0] avail;

   // a is older than b when (a - b) read as signed is negative; ties go to the lower index
   function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b,
                                  input int ia, input int ib);
      logic [ID_WIDTH-1:0] diff;
      diff  = a - b;
      older = diff[ID_WIDTH-1] || ((diff == '0) && (ia < ib));
   endfunction

   function automatic logic [UW-1:0] lowest_free(input logic [NUM_UNITS-1:0] m);
      lowest_free = '0;
      for (int u = NUM_UNITS - 1; u >= 0; u--) begin
         if (m[u]) lowest_free = UW'(u);
      end
   endfunction

   always_comb begin
      eligible = '0;
      win      = '0;
      avail    = ~unit_busy;
      for (int p = 0; p < NUM_PORTS; p++) begin
         eligible[p] = req_valid[p] && (state[p] != S_HELD);
         win_unit[p] = '0;
         rank[p]     = 0;
         cnt_inc[p]  = hold_cnt[p] + 1'b1;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int q = 0; q < NUM_PORTS; q++) begin
            if (q != p && eligible[q] && older(req_id[q], req_id[p], q, p)) rank[p] = rank[p] + 1;
         end
      end
      // Allocate in rank order so units are never double-assigned, even if ranks collide
      for (int k = 0; k < NUM_PORTS; k++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (eligible[p] && (rank[p] == k) && (avail != '0)) begin
               win[p]      = 1'b1;
               win_unit[p] = lowest_free(avail);
               avail[lowest_free(avail)] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant        <= '0;
         grant_unit   <= '0;
         unit_busy    <= '0;
         hold_timeout <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            state[p]    <= S_IDLE;
            hold_cnt[p] <= '0;
         end
      end else begin
         hold_timeout <= '0;
         if (flush) begin
            grant      <= '0;
            grant_unit <= '0;
            unit_busy  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
               state[p]    <= S_IDLE;
               hold_cnt[p] <= '0;
            end
         end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
               case (state[p])
                  S_IDLE, S_WAIT: begin
                     if (win[p]) begin
                        state[p]               <= S_HELD;
                        grant[p]               <= 1'b1;
                        grant_unit[p]          <= win_unit[p];
                        unit_busy[win_unit[p]] <= 1'b1;
                        hold_cnt[p]            <= '0;
                     end else if (req_valid[p]) begin
                        state[p] <= S_WAIT;
                     end else begin
                        state[p] <= S_IDLE;
                     end
                  end
                  S_HELD: begin
                     if (release_unit[p] || !req_valid[p] || (cnt_inc[p] == CW'(MAX_HOLD))) begin
                        state[p]                 <= S_IDLE;
                        grant[p]                 <= 1'b0;
                        grant_unit[p]            <= '0;
                        unit_busy[grant_unit[p]] <= 1'b0;
                        hold_cnt[p]              <= '0;
                        hold_timeout[p]          <= req_valid[p] && !release_unit[p];
                     end else begin
                        hold_cnt[p] <= cnt_inc[p];
                     end
                  end
                  default: begin
                     state[p] <= S_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_age_ordered_unit_arbiter.sv
// Directed bench: instance a has 4 units / MAX_HOLD=3, instance b has 1 unit / MAX_HOLD=15.
`default_nettype none

module tb_age_ordered_unit_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]       a_req, a_rel, a_grant, a_busy_x, a_to;
   logic [1:0][15:0] a_id;
   logic             a_flush;
   logic [1:0][1:0]  a_gu;
   logic [3:0]       a_busy;

   logic [1:0]       b_req, b_rel, b_grant, b_to;
   logic [1:0][15:0] b_id;
   logic             b_flush;
   logic [1:0][0:0]  b_gu;
   logic [0:0]       b_busy;

   int vectors    = 0;
   int miscompares = 0;

   age_ordered_unit_arbiter #(.NUM_PORTS(2), .NUM_UNITS(4), .ID_WIDTH(16), .MAX_HOLD(3)) u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_req), .req_id(a_id), .release_unit(a_rel),
      .flush(a_flush), .grant(a_grant), .grant_unit(a_gu), .unit_busy(a_busy), .hold_timeout(a_to));

   age_ordered_unit_arbiter #(.NUM_PORTS(2), .NUM_UNITS(1), .ID_WIDTH(16), .MAX_HOLD(15)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req), .req_id(b_id), .release_unit(b_rel),
      .flush(b_flush), .grant(b_grant), .grant_unit(b_gu), .unit_busy(b_busy), .hold_timeout(b_to));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_busy_x = '0;
      rst_n = 1'b0;
      a_req = '0; a_rel = '0; a_id = '0; a_flush = 1'b0;
      b_req = '0; b_rel = '0; b_id = '0; b_flush = 1'b0;
      step(); step();
      check("rst_a_grant", 32'(a_grant), 32'h0);
      check("rst_a_busy",  32'(a_busy),  32'h0);
      check("rst_a_to",    32'(a_to),    32'h0);
      check("rst_b_grant", 32'(b_grant), 32'h0);
      rst_n = 1'b1;
      step();

      // Single grant then release
      a_req = 2'b01; a_id[0] = 16'd5;
      step();
      check("single_grant", 32'(a_grant), 32'h1);
      check("single_unit",  32'(a_gu[0]), 32'h0);
      check("single_busy",  32'(a_busy),  32'h1);
      a_rel = 2'b01;
      step();
      check("rel_grant", 32'(a_grant), 32'h0);
      check("rel_busy",  32'(a_busy),  32'h0);
      a_rel = '0; a_req = '0;
      step();

      // Two requesters, plenty of units: older (port1) takes unit 0
      a_req = 2'b11; a_id[0] = 16'd20; a_id[1] = 16'd7;
      step();
      check("dual_grant", 32'(a_grant), 32'h3);
      check("dual_unit1", 32'(a_gu[1]), 32'h0);
      check("dual_unit0", 32'(a_gu[0]), 32'h1);
      check("dual_busy",  32'(a_busy),  32'h3);
      a_req = '0;
      step();
      check("dual_drop", 32'(a_busy), 32'h0);

      // Timeout: grant high exactly 3 cycles
      a_req = 2'b01; a_id[0] = 16'd9;
      step();
      check("to_c1", 32'({a_grant, a_to}), 32'h4);
      step();
      check("to_c2", 32'({a_grant, a_to}), 32'h4);
      step();
      check("to_c3", 32'({a_grant, a_to}), 32'h4);
      step();
      check("to_grant", 32'(a_grant), 32'h0);
      check("to_pulse", 32'(a_to),    32'h1);
      check("to_busy",  32'(a_busy),  32'h0);
      a_req = '0;
      step();
      check("to_pulse_end", 32'(a_to), 32'h0);

      // Flush with both held, then re-arbitration
      a_req = 2'b11; a_id[0] = 16'd1; a_id[1] = 16'd2;
      step();
      check("fl_pre", 32'(a_grant), 32'h3);
      a_flush = 1'b1;
      step();
      check("fl_grant", 32'(a_grant), 32'h0);
      check("fl_busy",  32'(a_busy),  32'h0);
      check("fl_to",    32'(a_to),    32'h0);
      a_flush = 1'b0;
      step();
      check("fl_regrant", 32'(a_grant), 32'h3);
      check("fl_rebusy",  32'(a_busy),  32'h3);
      a_req = '0;
      step();

      // Asynchronous reset mid-hold
      a_req = 2'b01; a_id[0] = 16'd3;
      step();
      check("ar_pre", 32'(a_grant), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_grant", 32'(a_grant), 32'h0);
      check("ar_busy",  32'(a_busy),  32'h0);
      a_req = '0;
      step();
      check("ar_held", 32'(a_grant), 32'h0);
      rst_n = 1'b1;
      a_req = 2'b01; a_id[0] = 16'd4;
      step();
      check("ar_fresh", 32'(a_grant), 32'h1);
      a_req = '0;
      step();

      // Scarcity: one unit, port1 (id 7) older than port0 (id 20)
      b_req = 2'b11; b_id[0] = 16'd20; b_id[1] = 16'd7;
      step();
      check("sc_grant", 32'(b_grant), 32'h2);
      check("sc_busy",  32'(b_busy),  32'h1);
      step();
      check("sc_wait", 32'(b_grant), 32'h2);
      b_rel = 2'b10;
      step();
      check("sc_rel", 32'(b_grant), 32'h0);
      check("sc_rel_busy", 32'(b_busy), 32'h0);
      b_rel = '0; b_req = 2'b01;
      step();
      check("sc_next", 32'(b_grant), 32'h1);
      b_req = '0;
      step();
      check("sc_idle", 32'(b_grant), 32'h0);

      // Wrap-around: 0xFFFE is older than 0x0001
      b_req = 2'b11; b_id[0] = 16'hFFFE; b_id[1] = 16'h0001;
      step();
      check("wrap_grant", 32'(b_grant), 32'h1);
      b_req = '0;
      step();
      b_req = 2'b11; b_id[0] = 16'h1234; b_id[1] = 16'h1234;
      step();
      check("tie_grant", 32'(b_grant), 32'h1);
      b_req = '0;
      step();
      check("tie_idle", 32'(b_busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
